// File: rtl/ysyx_041514_if_ctrl_if.sv
// Fetch request/response bus between the instruction-fetch sequencer and the
// instruction memory or icache port.

`ifndef ysyx_041514_XLEN_BUS
`define ysyx_041514_XLEN_BUS 63:0
`endif

interface ysyx_041514_if_ctrl_if;
   // Request: transfer when if_req_valid_o && if_req_ready_i on a rising edge;
   // the response returns later with if_resp_valid_i and cannot be stalled.
   logic                        if_req_valid_o;
   logic                        if_req_ready_i;
   logic [`ysyx_041514_XLEN_BUS] if_req_addr_o;
   logic                        if_resp_valid_i;
   logic [`ysyx_041514_XLEN_BUS] if_resp_data_i;

   modport master (
      output if_req_valid_o,
      output if_req_addr_o,
      input  if_req_ready_i,
      input  if_resp_valid_i,
      input  if_resp_data_i
   );

   modport slave (
      input  if_req_valid_o,
      input  if_req_addr_o,
      output if_req_ready_i,
      output if_resp_valid_i,
      output if_resp_data_i
   );
endinterface

// File: rtl/ysyx_041514_if_ctrl.sv
// Instruction-fetch request sequencer: one outstanding fetch, holds the result for IF/ID,
// drops responses of flushed fetches. YSYX_041514_IF_WORD_SEL_EN enables 32-bit word select.

`ifndef ysyx_041514_XLEN_BUS
`define ysyx_041514_XLEN_BUS 63:0
`endif

module ysyx_041514_if_ctrl (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [`ysyx_041514_XLEN_BUS] pc_i,
   input  logic                         if_ready_i,
   input  logic                         flush_i,
   ysyx_041514_if_ctrl_if.master        bus,
   output logic [`ysyx_041514_XLEN_BUS] inst_addr_o,
   output logic                         if_rdata_valid_o,
   output logic [`ysyx_041514_XLEN_BUS] if_rdata_o,
   output logic [1:0]                   o_dbg_state
);

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2,
      S_DROP = 2'd3
   } state_t;

   state_t                       r_state;
   state_t                       w_next_state;
   logic [`ysyx_041514_XLEN_BUS] r_addr_q;
   logic [`ysyx_041514_XLEN_BUS] r_data_q;
   logic                         w_handshake;
   logic                         w_capture;
   logic [`ysyx_041514_XLEN_BUS] w_req_addr;
   logic [`ysyx_041514_XLEN_BUS] w_cap_data;

`ifdef YSYX_041514_IF_WORD_SEL_EN
   // Memory is addressed by doubleword; the held PC picks the 32-bit half.
   assign w_req_addr = {pc_i[63:3], 3'b000};
   assign w_cap_data = {32'b0, (r_addr_q[2] ? bus.if_resp_data_i[63:32]
                                            : bus.if_resp_data_i[31:0])};
`else
   assign w_req_addr = pc_i;
   assign w_cap_data = bus.if_resp_data_i;
`endif

   assign w_handshake = (r_state == S_REQ) && bus.if_req_ready_i;

   always_comb begin
      w_next_state = r_state;
      w_capture    = 1'b0;
      case (r_state)
         S_REQ: begin
            if (w_handshake) begin
               w_next_state = flush_i ? S_DROP : S_WAIT;
            end
         end
         S_WAIT: begin
            // A flush always wins over capturing the response.
            if (bus.if_resp_valid_i) begin
               if (flush_i) begin
                  w_next_state = S_REQ;
               end else begin
                  w_next_state = S_HOLD;
                  w_capture    = 1'b1;
               end
            end else if (flush_i) begin
               w_next_state = S_DROP;
            end
         end
         S_HOLD: begin
            if (if_ready_i || flush_i) begin
               w_next_state = S_REQ;
            end
         end
         S_DROP: begin
            if (bus.if_resp_valid_i) begin
               w_next_state = S_REQ;
            end
         end
         default: begin
            w_next_state = S_REQ;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= S_REQ;
         r_addr_q <= '0;
         r_data_q <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_handshake) begin
            r_addr_q <= pc_i;
         end
         if (w_capture) begin
            r_data_q <= w_cap_data;
         end
      end
   end

   // Request valid is gated by reset so nothing is issued while reset is held.
   assign bus.if_req_valid_o = (r_state == S_REQ) && rst;
   assign bus.if_req_addr_o  = w_req_addr;

   assign if_rdata_valid_o = (r_state == S_HOLD);
   assign if_rdata_o       = r_data_q;
   assign inst_addr_o      = r_addr_q;
   assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_ysyx_041514_if_ctrl.sv
// Directed bench for ysyx_041514_if_ctrl: cycle-by-cycle vector table plus
// hand-written reset-in-HOLD / reset-in-WAIT sequences.

module tb_ysyx_041514_if_ctrl;

   logic        clk;
   logic        rst;
   logic [63:0] pc_i;
   logic        if_ready_i;
   logic        flush_i;
   logic [63:0] inst_addr_o;
   logic        if_rdata_valid_o;
   logic [63:0] if_rdata_o;
   logic [1:0]  o_dbg_state;

   ysyx_041514_if_ctrl_if bus ();

   ysyx_041514_if_ctrl dut (
      .clk              (clk),
      .rst              (rst),
      .pc_i             (pc_i),
      .if_ready_i       (if_ready_i),
      .flush_i          (flush_i),
      .bus              (bus.master),
      .inst_addr_o      (inst_addr_o),
      .if_rdata_valid_o (if_rdata_valid_o),
      .if_rdata_o       (if_rdata_o),
      .o_dbg_state      (o_dbg_state)
   );

   localparam logic [1:0] ST_REQ  = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;
   localparam logic [1:0] ST_DROP = 2'd3;

`ifdef YSYX_041514_IF_WORD_SEL_EN
   localparam logic [63:0] WS_ADDR = 64'h0000_0000_8000_0000;
   localparam logic [63:0] WS_DATA = 64'h0000_0000_1111_1111;
`else
   localparam logic [63:0] WS_ADDR = 64'h0000_0000_8000_0004;
   localparam logic [63:0] WS_DATA = 64'h1111_1111_2222_2222;
`endif

   // clock/reset block
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int check_cnt = 0;
   int fail_cnt  = 0;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      check_cnt++;
      if (got !== exp) begin
         fail_cnt++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic drive(input logic [63:0] pc, input logic rdy, input logic fl,
                        input logic qr, input logic rv, input logic [63:0] rd);
      pc_i                = pc;
      if_ready_i          = rdy;
      flush_i             = fl;
      bus.if_req_ready_i  = qr;
      bus.if_resp_valid_i = rv;
      bus.if_resp_data_i  = rd;
   endtask

   typedef struct {
      logic [63:0] pc;
      logic        rdy;
      logic        fl;
      logic        qr;
      logic        rv;
      logic [63:0] rd;
      logic        e_qv;
      logic [63:0] e_qa;
      logic        e_v;
      logic [63:0] e_d;
      logic [63:0] e_ia;
      logic [1:0]  e_st;
   } vec_t;

   function automatic vec_t mk(input logic [63:0] pc, input logic rdy, input logic fl,
                               input logic qr, input logic rv, input logic [63:0] rd,
                               input logic e_qv, input logic [63:0] e_qa, input logic e_v,
                               input logic [63:0] e_d, input logic [63:0] e_ia,
                               input logic [1:0] e_st);
      vec_t v;
      v.pc = pc; v.rdy = rdy; v.fl = fl; v.qr = qr; v.rv = rv; v.rd = rd;
      v.e_qv = e_qv; v.e_qa = e_qa; v.e_v = e_v; v.e_d = e_d; v.e_ia = e_ia;
      v.e_st = e_st;
      return v;
   endfunction

   localparam int NV = 29;
   vec_t vecs [NV];

   initial begin
      // Fetch, 5-cycle stall, accept, flush in WAIT, flush on handshake,
      // flush on response, flush over accept, flush in REQ, word select.
      //              pc                    rdy  fl   qr   rv   rd                       qv   qa                     v    d                      ia                     st
      vecs[0]  = mk(64'h8000_0000,        0,   0,   0,   0,   64'h0,                   1,   64'h8000_0000,         0,   64'h0,                 64'h0,                 ST_REQ);
      vecs[1]  = mk(64'h8000_0000,        0,   0,   1,   0,   64'h0,                   1,   64'h8000_0000,         0,   64'h0,                 64'h0,                 ST_REQ);
      vecs[2]  = mk(64'h8000_0000,        0,   0,   0,   0,   64'h0,                   0,   64'h0,                 0,   64'h0,                 64'h0,                 ST_WAIT);
      vecs[3]  = mk(64'h8000_0000,        0,   0,   0,   1,   64'h13,                  0,   64'h0,                 0,   64'h0,                 64'h0,                 ST_WAIT);
      for (int i = 4; i < 9; i++)
         vecs[i] = mk(64'h8000_0000,      0,   0,   0,   0,   64'h0,                   0,   64'h0,                 1,   64'h13,                64'h8000_0000,         ST_HOLD);
      vecs[9]  = mk(64'h8000_0000,        1,   0,   0,   0,   64'h0,                   0,   64'h0,                 1,   64'h13,                64'h8000_0000,         ST_HOLD);
      vecs[10] = mk(64'h8000_0004,        0,   0,   1,   0,   64'h0,                   1,   64'h8000_0004,         0,   64'h0,                 64'h0,                 ST_REQ);
      vecs[11] = mk(64'h8000_0100,        0,   1,   0,   0,   64'h0,                   0,   64'h0,                 0,   64'h0,                 64'h0,                 ST_WAIT);
      vecs[12] = mk(64'h8000_0100,        0,   0,   0,   0,   64'h0,                   0,   64'h0,                 0,   64'h0,                 64'h0,                 ST_DROP);
      vecs[13] = mk(64'h8000_0100,        0,   0,   0,   0,   64'h0,                   0,   64'h0,                 0,   64'h0,                 64'h0,                 ST_DROP);
      vecs[14] = mk(64'h8000_0100,        0,   0,   0,   1,   64'hDEAD_BEEF,           0,   64'h0,                 0,   64'h0,                 64'h0,                 ST_DROP);
      vecs[15] = mk(64'h8000_0100,        0,   0,   0,   0,   64'h0,                   1,   64'h8000_0100,         0,   64'h0,                 64'h0,                 ST_REQ);
      vecs[16] = mk(64'h8000_0200,        0,   1,   1,   0,   64'h0,                   1,   64'h8000_0200,         0,   64'h0,                 64'h0,                 ST_REQ);
      vecs[17] = mk(64'h8000_0200,        0,   0,   0,   1,   64'hBAD0_BAD0,           0,   64'h0,                 0,   64'h0,                 64'h0,                 ST_DROP);
      vecs[18] = mk(64'h8000_0200,        0,   0,   1,   0,   64'h0,                   1,   64'h8000_0200,         0,   64'h0,                 64'h0,                 ST_REQ);
      vecs[19] = mk(64'h8000_0300,        0,   1,   0,   1,   64'hBAAD_0000,           0,   64'h0,                 0,   64'h0,                 64'h0,                 ST_WAIT);
      vecs[20] = mk(64'h8000_0300,        0,   0,   1,   0,   64'h0,                   1,   64'h8000_0300,         0,   64'h0,                 64'h0,                 ST_REQ);
      vecs[21] = mk(64'h8000_0300,        0,   0,   0,   1,   64'h93,                  0,   64'h0,                 0,   64'h0,                 64'h0,                 ST_WAIT);
      vecs[22] = mk(64'h8000_0400,        1,   1,   0,   0,   64'h0,                   0,   64'h0,                 1,   64'h93,                64'h8000_0300,         ST_HOLD);
      vecs[23] = mk(64'h8000_0500,        0,   1,   0,   1,   64'h5555,                1,   64'h8000_0500,         0,   64'h0,                 64'h0,                 ST_REQ);
      vecs[24] = mk(64'h8000_0500,        0,   0,   0,   0,   64'h0,                   1,   64'h8000_0500,         0,   64'h0,                 64'h0,                 ST_REQ);
      vecs[25] = mk(64'h8000_0004,        0,   0,   1,   0,   64'h0,                   1,   WS_ADDR,               0,   64'h0,                 64'h0,                 ST_REQ);
      vecs[26] = mk(64'h8000_0004,        0,   0,   0,   1,   64'h1111_1111_2222_2222, 0,   64'h0,                 0,   64'h0,                 64'h0,                 ST_WAIT);
      vecs[27] = mk(64'h8000_0004,        1,   0,   0,   0,   64'h0,                   0,   64'h0,                 1,   WS_DATA,               64'h8000_0004,         ST_HOLD);
      vecs[28] = mk(64'h8000_0008,        0,   0,   0,   0,   64'h0,                   1,   64'h8000_0008,         0,   64'h0,                 64'h0,                 ST_REQ);
   end

   initial begin
      rst = 1'b0;
      drive(64'h8000_0000, 0, 0, 0, 0, 64'h0);
      #2;
      chk("rst req_valid", {63'b0, bus.if_req_valid_o}, 64'h0);
      chk("rst rdata_valid", {63'b0, if_rdata_valid_o}, 64'h0);
      chk("rst rdata", if_rdata_o, 64'h0);
      chk("rst inst_addr", inst_addr_o, 64'h0);
      chk("rst state", {62'b0, o_dbg_state}, {62'b0, ST_REQ});

      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].pc, vecs[i].rdy, vecs[i].fl, vecs[i].qr, vecs[i].rv, vecs[i].rd);
         #1;
         chk($sformatf("v%0d req_valid", i), {63'b0, bus.if_req_valid_o}, {63'b0, vecs[i].e_qv});
         chk($sformatf("v%0d rdata_valid", i), {63'b0, if_rdata_valid_o}, {63'b0, vecs[i].e_v});
         chk($sformatf("v%0d state", i), {62'b0, o_dbg_state}, {62'b0, vecs[i].e_st});
         if (vecs[i].e_qv)
            chk($sformatf("v%0d req_addr", i), bus.if_req_addr_o, vecs[i].e_qa);
         if (vecs[i].e_v) begin
            chk($sformatf("v%0d rdata", i), if_rdata_o, vecs[i].e_d);
            chk($sformatf("v%0d inst_addr", i), inst_addr_o, vecs[i].e_ia);
         end
         @(negedge clk);
      end

      // Reset asserted while holding an instruction.
      drive(64'h8000_1000, 0, 0, 1, 0, 64'h0);
      @(negedge clk);
      drive(64'h8000_1000, 0, 0, 0, 1, 64'h1234);
      @(negedge clk);
      drive(64'h8000_1000, 0, 0, 0, 0, 64'h0);
      #1;
      chk("hold pre rdata_valid", {63'b0, if_rdata_valid_o}, 64'h1);
      chk("hold pre rdata", if_rdata_o, 64'h1234);
      chk("hold pre inst_addr", inst_addr_o, 64'h8000_1000);
      #2 rst = 1'b0;
      #1;
      chk("hold rst rdata_valid", {63'b0, if_rdata_valid_o}, 64'h0);
      chk("hold rst rdata", if_rdata_o, 64'h0);
      chk("hold rst inst_addr", inst_addr_o, 64'h0);
      chk("hold rst req_valid", {63'b0, bus.if_req_valid_o}, 64'h0);
      @(negedge clk);
      rst = 1'b1;
      drive(64'h8000_1000, 0, 0, 0, 1, 64'hFFFF);
      #1;
      chk("hold rel req_valid", {63'b0, bus.if_req_valid_o}, 64'h1);
      chk("hold rel req_addr", bus.if_req_addr_o, 64'h8000_1000);
      @(negedge clk);
      drive(64'h8000_1000, 0, 0, 0, 0, 64'h0);
      #1;
      chk("hold late state", {62'b0, o_dbg_state}, {62'b0, ST_REQ});
      chk("hold late rdata_valid", {63'b0, if_rdata_valid_o}, 64'h0);

      // Reset asserted while waiting for a response.
      drive(64'h8000_2000, 0, 0, 1, 0, 64'h0);
      @(negedge clk);
      drive(64'h8000_2000, 0, 0, 0, 0, 64'h0);
      #1;
      chk("wait pre state", {62'b0, o_dbg_state}, {62'b0, ST_WAIT});
      #2 rst = 1'b0;
      #1;
      chk("wait rst state", {62'b0, o_dbg_state}, {62'b0, ST_REQ});
      chk("wait rst req_valid", {63'b0, bus.if_req_valid_o}, 64'h0);
      chk("wait rst inst_addr", inst_addr_o, 64'h0);
      chk("wait rst rdata", if_rdata_o, 64'h0);
      @(negedge clk);
      rst = 1'b1;
      drive(64'h8000_2000, 0, 0, 0, 1, 64'hBEEF);
      #1;
      chk("wait rel req_valid", {63'b0, bus.if_req_valid_o}, 64'h1);
      chk("wait rel req_addr", bus.if_req_addr_o, 64'h8000_2000);
      @(negedge clk);
      drive(64'h8000_2000, 0, 0, 1, 0, 64'h0);
      #1;
      chk("wait late state", {62'b0, o_dbg_state}, {62'b0, ST_REQ});
      chk("wait late rdata_valid", {63'b0, if_rdata_valid_o}, 64'h0);
      @(negedge clk);
      drive(64'h8000_2000, 0, 0, 0, 1, 64'h73);
      @(negedge clk);
      drive(64'h8000_2000, 0, 0, 0, 0, 64'h0);
      #1;
      chk("post rdata_valid", {63'b0, if_rdata_valid_o}, 64'h1);
      chk("post rdata", if_rdata_o, 64'h73);
      chk("post inst_addr", inst_addr_o, 64'h8000_2000);

      $display("End of test - %0d assertions evaluated, %0d failures", check_cnt, fail_cnt);
      $finish;
   end

endmodule
